// File: rtl/dcache_flush.sv
// Flush/invalidate engine for the 4-way dcache state array: walks every (set, way),
// writes back dirty+valid lines over a req/ack handshake and clears each live entry.
`ifndef D_INDEX_WIDTH
`define D_INDEX_WIDTH 8
`endif

module dcache_flush #(
    parameter int aw  = `D_INDEX_WIDTH,
    parameter int num = (1 << aw),
    parameter int dw  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_req,
    input  logic          inv_only,
    output logic          busy,
    output logic          done,
    output logic          st_en,
    output logic          st_we,
    output logic [aw-1:0] st_index,
    output logic [1:0]    st_way,
    output logic [dw-1:0] st_din,
    input  logic [dw-1:0] st_dout0,
    input  logic [dw-1:0] st_dout1,
    input  logic [dw-1:0] st_dout2,
    input  logic [dw-1:0] st_dout3,
    output logic          wb_req,
    output logic [aw-1:0] wb_index,
    output logic [1:0]    wb_way,
    input  logic          wb_ack,
    output logic [15:0]   wb_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WB,
        S_CLEAR,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [aw-1:0] LAST_IDX = aw'(num - 1);

    state_t          r_state;
    logic [aw-1:0]   r_idx;
    logic [1:0]      r_way;
    logic            r_inv;
    logic [15:0]     r_wb_count;
    logic [dw-1:0]   w_cur;

    always_comb begin
        w_cur = st_dout0;
        case (r_way)
            2'd1:    w_cur = st_dout1;
            2'd2:    w_cur = st_dout2;
            2'd3:    w_cur = st_dout3;
            default: w_cur = st_dout0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_way      <= '0;
            r_inv      <= 1'b0;
            r_wb_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush_req) begin
                        r_idx      <= '0;
                        r_way      <= '0;
                        r_inv      <= inv_only;
                        r_wb_count <= '0;
                        r_state    <= S_READ;
                    end
                end
                // Dirty-but-invalid (2'b10) falls through to NEXT untouched.
                S_READ: begin
                    if (w_cur[1] && w_cur[0] && !r_inv)
                        r_state <= S_WB;
                    else if (w_cur[0])
                        r_state <= S_CLEAR;
                    else
                        r_state <= S_NEXT;
                end
                S_WB: begin
                    if (wb_ack) begin
                        if (r_wb_count != 16'hFFFF)
                            r_wb_count <= r_wb_count + 16'd1;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: r_state <= S_NEXT;
                S_NEXT: begin
                    if (r_way != 2'd3) begin
                        r_way   <= r_way + 2'd1;
                        r_state <= S_READ;
                    end else if (r_idx != LAST_IDX) begin
                        r_way   <= 2'd0;
                        r_idx   <= r_idx + aw'(1);
                        r_state <= S_READ;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign st_en    = (r_state == S_READ) || (r_state == S_CLEAR);
    assign st_we    = (r_state == S_CLEAR);
    assign st_din   = '0;
    assign st_index = r_idx;
    assign st_way   = r_way;
    assign wb_req   = (r_state == S_WB);
    assign wb_index = r_idx;
    assign wb_way   = r_way;
    assign wb_count = r_wb_count;

endmodule

// File: tb/tb_dcache_flush.sv
// Directed bench for dcache_flush with num=4 sets and a behavioural state RAM.
module tb_dcache_flush;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_req;
    logic        inv_only;
    logic        busy, done, st_en, st_we;
    logic [1:0]  st_index, st_way, st_din;
    logic [1:0]  st_dout0, st_dout1, st_dout2, st_dout3;
    logic        wb_req;
    logic [1:0]  wb_index, wb_way;
    logic        wb_ack = 1'b0;
    logic [15:0] wb_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dcache_flush #(.aw(2), .num(4), .dw(2)) dut (
        .clk(clk), .rst(rst), .flush_req(flush_req), .inv_only(inv_only),
        .busy(busy), .done(done), .st_en(st_en), .st_we(st_we),
        .st_index(st_index), .st_way(st_way), .st_din(st_din),
        .st_dout0(st_dout0), .st_dout1(st_dout1), .st_dout2(st_dout2), .st_dout3(st_dout3),
        .wb_req(wb_req), .wb_index(wb_index), .wb_way(wb_way), .wb_ack(wb_ack),
        .wb_count(wb_count)
    );

    // Behavioural state RAM: combinational read of all four ways, synchronous write.
    logic [1:0] mem [0:3][0:3];
    assign st_dout0 = mem[st_index][0];
    assign st_dout1 = mem[st_index][1];
    assign st_dout2 = mem[st_index][2];
    assign st_dout3 = mem[st_index][3];
    always @(posedge clk) if (st_en && st_we) mem[st_index][st_way] <= st_din;

    // Writeback responder: acks ack_delay cycles after wb_req rises.
    int ack_delay = 0;
    int wb_wait   = 0;
    always @(negedge clk) begin
        if (wb_req) begin
            wb_ack = (wb_wait == ack_delay);
            wb_wait++;
        end else begin
            wb_ack  = 1'b0;
            wb_wait = 0;
        end
    end

    // Activity recorder, sampled on the falling edge.
    int n_busy, done_at, n_done, n_we, n_wbreq, n_wb_rise, wb_unstable, we_after_wb, bad_din;
    logic prev_wbreq = 1'b0, prev_busy = 1'b0;
    logic [1:0] first_idx, first_way, cap_idx, cap_way;
    logic [3:0] we_log [$];
    logic [3:0] wb_log [$];

    always @(negedge clk) begin
        if (busy) n_busy++;
        if (busy && !prev_busy) begin
            first_idx = st_index;
            first_way = st_way;
        end
        if (done) begin
            done_at = n_busy;
            n_done++;
        end
        if (st_we) begin
            n_we++;
            we_log.push_back({st_index, st_way});
            if (st_din !== 2'b00) bad_din++;
            if (prev_wbreq) we_after_wb++;
        end
        if (wb_req) begin
            n_wbreq++;
            if (!prev_wbreq) begin
                n_wb_rise++;
                cap_idx = wb_index;
                cap_way = wb_way;
                wb_log.push_back({wb_index, wb_way});
            end else if (wb_index !== cap_idx || wb_way !== cap_way) begin
                wb_unstable++;
            end
        end
        prev_wbreq = wb_req;
        prev_busy  = busy;
    end

    task automatic clear_mon();
        n_busy = 0; done_at = 0; n_done = 0; n_we = 0; n_wbreq = 0; n_wb_rise = 0;
        wb_unstable = 0; we_after_wb = 0; bad_din = 0;
        we_log.delete();
        wb_log.delete();
    endtask

    task automatic fill_mem(input logic [1:0] v);
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 4; w++)
                mem[s][w] = v;
    endtask

    function automatic int nonzero();
        int n = 0;
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 4; w++)
                if (mem[s][w] !== 2'b00) n++;
        return n;
    endfunction

    task automatic run_flush(input logic inv, input int budget);
        @(negedge clk);
        flush_req = 1'b1;
        inv_only  = inv;
        @(negedge clk);
        flush_req = 1'b0;
        inv_only  = 1'b0;
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL flush_timeout: done=%b required 1 within %0d cycles", done, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_req = 1'b0; inv_only = 1'b0;
        fill_mem(2'b00);
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if ({st_en, st_we, wb_req} !== 3'b000) begin bad++; $display("FAIL reset_ctl: en/we/req=%b want 000", {st_en, st_we, wb_req}); end
        total++; if ({st_index, st_way, wb_index, wb_way, st_din} !== 10'd0) begin bad++; $display("FAIL reset_addr: got %h want 0", {st_index, st_way, wb_index, wb_way, st_din}); end
        total++; if (wb_count !== 16'd0) begin bad++; $display("FAIL reset_wbcount: got %0d want 0", wb_count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_empty();
        fill_mem(2'b00);
        clear_mon();
        run_flush(1'b0, 100);
        total++; if (n_busy !== 33) begin bad++; $display("FAIL empty_busy: got %0d want 33", n_busy); end
        total++; if (done_at !== 33) begin bad++; $display("FAIL empty_done_cycle: got %0d want 33", done_at); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL empty_done_pulses: got %0d want 1", n_done); end
        total++; if (n_we !== 0) begin bad++; $display("FAIL empty_we: got %0d want 0", n_we); end
        total++; if (n_wbreq !== 0) begin bad++; $display("FAIL empty_wbreq: got %0d want 0", n_wbreq); end
        total++; if (wb_count !== 16'd0) begin bad++; $display("FAIL empty_wbcount: got %0d want 0", wb_count); end
    endtask

    task automatic test_dirty_clean();
        fill_mem(2'b00);
        mem[1][2] = 2'b11;
        mem[3][0] = 2'b01;
        ack_delay = 0;
        clear_mon();
        run_flush(1'b0, 100);
        total++; if (n_wb_rise !== 1) begin bad++; $display("FAIL dc_wb_count_req: got %0d want 1", n_wb_rise); end
        total++; if (wb_log.size() < 1 || wb_log[0] !== 4'b0110) begin bad++; $display("FAIL dc_wb_addr: got %h want 6", (wb_log.size() > 0) ? wb_log[0] : 4'hx); end
        total++; if (n_we !== 2) begin bad++; $display("FAIL dc_we_count: got %0d want 2", n_we); end
        total++; if (we_log.size() != 2 || we_log[0] !== 4'b0110 || we_log[1] !== 4'b1100) begin bad++; $display("FAIL dc_we_order: got %0d entries want (1,2),(3,0)", we_log.size()); end
        total++; if (bad_din !== 0) begin bad++; $display("FAIL dc_din: got %0d nonzero writes want 0", bad_din); end
        total++; if (wb_count !== 16'd1) begin bad++; $display("FAIL dc_wbcount: got %0d want 1", wb_count); end
        total++; if (nonzero() !== 0) begin bad++; $display("FAIL dc_mem_clear: got %0d live entries want 0", nonzero()); end
        total++; if (n_busy !== 36) begin bad++; $display("FAIL dc_busy: got %0d want 36", n_busy); end
    endtask

    task automatic test_delayed_ack();
        fill_mem(2'b00);
        mem[2][3] = 2'b11;
        ack_delay = 5;
        clear_mon();
        run_flush(1'b0, 100);
        total++; if (n_wbreq !== 6) begin bad++; $display("FAIL dl_req_cycles: got %0d want 6", n_wbreq); end
        total++; if (wb_unstable !== 0) begin bad++; $display("FAIL dl_req_stable: got %0d changes want 0", wb_unstable); end
        total++; if (wb_log.size() < 1 || wb_log[0] !== 4'b1011) begin bad++; $display("FAIL dl_wb_addr: got %h want b", (wb_log.size() > 0) ? wb_log[0] : 4'hx); end
        total++; if (we_after_wb !== 1) begin bad++; $display("FAIL dl_clear_after_ack: got %0d want 1", we_after_wb); end
        total++; if (wb_count !== 16'd1) begin bad++; $display("FAIL dl_wbcount: got %0d want 1", wb_count); end
        total++; if (n_busy !== 40) begin bad++; $display("FAIL dl_busy: got %0d want 40", n_busy); end
        ack_delay = 0;
    endtask

    task automatic test_inv_only();
        fill_mem(2'b11);
        clear_mon();
        run_flush(1'b1, 100);
        total++; if (n_wbreq !== 0) begin bad++; $display("FAIL inv_wbreq: got %0d want 0", n_wbreq); end
        total++; if (n_we !== 16) begin bad++; $display("FAIL inv_we: got %0d want 16", n_we); end
        total++; if (n_busy !== 49) begin bad++; $display("FAIL inv_busy: got %0d want 49", n_busy); end
        total++; if (wb_count !== 16'd0) begin bad++; $display("FAIL inv_wbcount: got %0d want 0", wb_count); end
        total++; if (nonzero() !== 0) begin bad++; $display("FAIL inv_mem_clear: got %0d live entries want 0", nonzero()); end
    endtask

    task automatic test_reset_mid();
        fill_mem(2'b00);
        mem[0][1] = 2'b11;
        ack_delay = 1000;
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        for (int i = 0; i < 20 && !wb_req; i++) @(negedge clk);
        total++; if (wb_req !== 1'b1 || wb_index !== 2'd0 || wb_way !== 2'd1) begin bad++; $display("FAIL rm_in_wb: req=%b idx=%0d way=%0d want 1,0,1", wb_req, wb_index, wb_way); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0 || wb_req !== 1'b0) begin bad++; $display("FAIL rm_abort: busy=%b req=%b want 0,0", busy, wb_req); end
        total++; if ({st_en, st_we, done, st_index, st_way, wb_count} !== 21'd0) begin bad++; $display("FAIL rm_outputs: got %h want 0", {st_en, st_we, done, st_index, st_way, wb_count}); end
        ack_delay = 0;
        clear_mon();
        run_flush(1'b0, 100);
        total++; if (first_idx !== 2'd0 || first_way !== 2'd0) begin bad++; $display("FAIL rm_restart: idx=%0d way=%0d want 0,0", first_idx, first_way); end
        total++; if (n_wb_rise !== 1 || wb_log.size() < 1 || wb_log[0] !== 4'b0001) begin bad++; $display("FAIL rm_rewb: got %0d writebacks want 1 at (0,1)", n_wb_rise); end
        total++; if (wb_count !== 16'd1) begin bad++; $display("FAIL rm_wbcount: got %0d want 1", wb_count); end
        total++; if (n_busy !== 35) begin bad++; $display("FAIL rm_busy: got %0d want 35", n_busy); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        fill_mem(2'b00);
        clear_mon();
        @(negedge clk);
        flush_req = 1'b1;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        total++; if (cyc !== 33) begin bad++; $display("FAIL b2b_done_cycle: got %0d want 33", cyc); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL b2b_done_ignored: busy=%b done=%b want 0,0", busy, done); end
        @(negedge clk);
        flush_req = 1'b0;
        total++; if (busy !== 1'b1 || st_index !== 2'd0 || st_way !== 2'd0) begin bad++; $display("FAIL b2b_restart: busy=%b idx=%0d way=%0d want 1,0,0", busy, st_index, st_way); end
        for (int i = 0; i < 100 && !done; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        total++; if (n_done !== 2) begin bad++; $display("FAIL b2b_done_pulses: got %0d want 2", n_done); end
        total++; if (n_busy !== 66) begin bad++; $display("FAIL b2b_busy: got %0d want 66", n_busy); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_dirty_clean();
        test_delayed_ack();
        test_inv_only();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_flush.md
# dcache_flush

Flush/invalidate engine for the 4-way data cache state array. On request it walks every set and way of the dirty/valid RAM, reading each entry. It hands each dirty+valid line to the memory side over a req/ack writeback handshake, then clears the entry's state to 2'b00. It sits between the cache controller (flush command) and the dsram state array (index/way/din/we/en, dout0..dout3).

## Interface
- `aw`, default `D_INDEX_WIDTH: log2 of the number of cache sets.
- `num`, default (1 << aw): number of sets.
- `dw`, default 2: state width; bit1 = dirty, bit0 = valid.

Ports:
- clk  in  1  clock; one clock domain, all state on posedge clk.
- rst  in  1  synchronous reset, active high.
- flush_req  in  1  start pulse; sampled only in IDLE.
- inv_only  in  1  sampled with flush_req; 1 = invalidate without writeback.
- busy  out  1  high from the cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- st_en  out  1  state RAM enable.
- st_we  out  1  state RAM write enable.
- st_index  out  aw  state RAM set index.
- st_way  out  2  state RAM way select.
- st_din  out  dw  state RAM write data; always 2'b00.
- st_dout0..st_dout3  in  dw each  state RAM combinational read data, ways 0..3.
- wb_req  out  1  writeback request.
- wb_index  out  aw  set index of the line being written back.
- wb_way  out  2  way of the line being written back.
- wb_ack  in  1  writeback accepted.
- wb_count  out  16  writebacks in the current or last flush; saturates at 16'hFFFF.

## Operation
- Registers: state, idx (aw bits), way (2 bits), inv (latched inv_only), wb_count.
- Outputs are a Moore decode of the registers. st_index = idx, st_way = way, wb_index = idx, wb_way = way in every state.
- Current entry: cur = st_dout[way], muxed from st_dout0..3.
- IDLE: busy=0, st_en=0.
  - flush_req=1 -> idx<=0, way<=0, inv<=inv_only, wb_count<=0, go to READ.
- READ: st_en=1, st_we=0.
  - cur = 2'b11 and inv=0 -> WB.
  - otherwise cur[0]=1 -> CLEAR.
  - otherwise -> NEXT.
  - cur = 2'b10 (dirty, not valid) is treated as invalid: no write, no writeback.
- WB: wb_req=1, st_en=0.
  - Stays in WB until wb_ack=1 is sampled.
  - On ack: wb_count increments (saturating) and state goes to CLEAR.
- CLEAR: st_en=1, st_we=1, st_din=2'b00, one cycle -> NEXT.
- NEXT: st_en=0.
  - way<3 -> way+1, go to READ.
  - way=3 and idx<num-1 -> way<=0, idx+1, go to READ.
  - way=3 and idx=num-1 -> DONE.
- DONE: done=1, busy=1, one cycle -> IDLE.
- flush_req outside IDLE is ignored; no queuing.
- wb_ack outside WB is ignored.
- inv_only is ignored except when sampled at acceptance.
- The walk order is set-major: (0,0),(0,1)…(0,3),(1,0)…(num-1,3).

## Timing
- Reset values: state=IDLE; busy, done, st_en, st_we, wb_req = 0; st_index, st_way, wb_index, wb_way, wb_count = 0; st_din = 2'b00.
- rst takes priority over every transition.
  - Reset mid-flush aborts on that edge.
  - A CLEAR write in progress on a reset cycle still presents st_we for that cycle, but the FSM is IDLE afterwards.
  - wb_req drops the cycle after rst is sampled.
- Acceptance: flush_req high at edge N in IDLE -> busy=1 and READ of (0,0) during cycle N+1.
- Cycles per entry:
  - invalid: 2 (READ, NEXT).
  - valid-clean, or inv=1: 3 (READ, CLEAR, NEXT).
  - dirty: 3 + k, where k ≥ 1 is WB cycles including the ack cycle.
- wb_req, wb_index and wb_way are stable from WB entry until the cycle wb_ack is sampled high. wb_req is low the next cycle.
- Empty cache: busy lasts 8·num + 1 cycles; done is in the last of them.

## Test plan
Bench overrides aw=2 (num=4); st_dout0..3 come from a behavioural dsram model.

- All entries 2'b00, flush_req pulse -> busy high for 33 cycles, done in cycle 33, st_we never high, wb_req never high, wb_count=0.
- (1,2)=2'b11, (3,0)=2'b01, wb_ack immediate -> exactly one wb_req with wb_index=1, wb_way=2. st_we pulses with st_din=00 at (1,2) then (3,0). wb_count=1. Model all zero at end.
- Dirty line at (2,3), wb_ack delayed 5 cycles -> wb_req held 6 cycles with wb_index=2 and wb_way=3 unchanged. Clear write follows the ack cycle.
- inv_only=1, every entry 2'b11 -> no wb_req, 16 st_we pulses, busy for 49 cycles, wb_count=0.
- rst asserted during WB at (0,1) -> next cycle busy=0, wb_req=0, outputs at reset values. A new flush_req restarts at (0,0) with wb_count=0.
- flush_req pulsed every cycle during a flush -> single done pulse; the walk is not restarted. flush_req in the DONE cycle is ignored; flush_req one cycle later starts a new flush.
